// File: rtl/fib_tp_pkg.sv
// Shared types and helpers for the two-phase Fibonacci sequencer.
package fib_tp_pkg;

  typedef enum logic [2:0] {IDLE, RST, START, WAIT, CHECK, DONE} state_t;

  localparam int RAIL_NUM = 2;

  // Phase of one bit: rail[0] carries the value, rail[0]^rail[1] the phase.
  function automatic logic tp_phase(input logic [RAIL_NUM-1:0] rails);
    return rails[0] ^ rails[1];
  endfunction

endpackage

// File: rtl/fib_tp_seq_ctrl_detect.sv
// Token detector: synchronizes every rail, then accepts a word whose bits all
// carry the expected phase and which is identical on two consecutive samples.
module tp_word_detect
  import fib_tp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0]   fib_in,
  input  logic                             exp_ph,
  output logic                             accept,
  output logic [WIDTH-1:0]                 value
);

  logic [WIDTH-1:0][RAIL_NUM-1:0] sync1, sync2, prev;
  logic                           all_ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= fib_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_comb begin
    all_ph = 1'b1;
    value  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      value[i] = sync2[i][0];
      if (tp_phase(sync2[i]) != exp_ph) all_ph = 1'b0;
    end
  end

  // Stability filter rejects skewed or glitching rails caught mid-transition.
  assign accept = all_ph && (sync2 == prev);

endmodule

// File: rtl/fib_tp_seq_ctrl.sv
// Sequencer for the fib_tp core: resets, starts, acks and golden-checks each term.
//  state | meaning
//  IDLE  | core held in reset, waiting for go
//  RST   | core reset for RST_CYC cycles
//  START | release reset, raise start
//  WAIT  | waiting for next token, timeout running
//  CHECK | compare token with golden, toggle ack
//  DONE  | results valid, core back in reset
module fib_tp_seq_ctrl
  import fib_tp_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int RST_CYC = 8,
  parameter int TMO_CYC = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  input  logic [CNT_W-1:0]               n_terms,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0] fib_in,
  output logic                           fib_rst,
  output logic                           fib_start,
  output logic                           fib_ack,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [CNT_W-1:0]               term_cnt,
  output logic [WIDTH-1:0]               last_val,
  output logic [CNT_W-1:0]               err_idx,
  output logic [WIDTH-1:0]               err_val,
  output logic                           tmo
);

  localparam int TMR_W = $clog2(TMO_CYC + 1);
  localparam int RC_W  = $clog2(RST_CYC + 1);

  state_t             state, state_nxt;
  logic               go_q, go_rise;
  logic [RC_W-1:0]    rst_cnt;
  logic [TMR_W-1:0]   tmr;
  logic               exp_ph;
  logic [WIDTH-1:0]   gold_a, gold_b, acc_val;
  logic               err_seen;
  logic               accept;
  logic [WIDTH-1:0]   value;
  logic [CNT_W:0]     term_inc;
  logic               last_term;

  tp_word_detect #(.WIDTH(WIDTH)) u_detect (
    .clk    (clk),
    .rst    (rst),
    .fib_in (fib_in),
    .exp_ph (exp_ph),
    .accept (accept),
    .value  (value)
  );

  assign go_rise   = go & ~go_q;
  assign term_inc  = {1'b0, term_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign last_term = (term_inc == {1'b0, n_terms});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fib_rst   = 1'b0;
    fib_start = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      IDLE: begin
        fib_rst = 1'b1;
        if (go_rise) state_nxt = (n_terms == '0) ? DONE : RST;
      end
      RST: begin
        fib_rst = 1'b1;
        busy    = 1'b1;
        if (rst_cnt == '0) state_nxt = START;
      end
      START: begin
        fib_start = 1'b1;
        busy      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        fib_start = 1'b1;
        busy      = 1'b1;
        if (accept)          state_nxt = CHECK;
        else if (tmr == '0)  state_nxt = DONE;
      end
      CHECK: begin
        fib_start = 1'b1;
        busy      = 1'b1;
        state_nxt = last_term ? DONE : WAIT;
      end
      DONE: begin
        fib_rst = 1'b1;
        done    = 1'b1;
        pass    = !tmo && !err_seen;
        if (go_rise) state_nxt = (n_terms == '0) ? DONE : RST;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q     <= 1'b0;
      rst_cnt  <= '0;
      tmr      <= '0;
      exp_ph   <= 1'b0;
      fib_ack  <= 1'b0;
      gold_a   <= '0;
      gold_b   <= '0;
      acc_val  <= '0;
      err_seen <= 1'b0;
      term_cnt <= '0;
      last_val <= '0;
      err_idx  <= '0;
      err_val  <= '0;
      tmo      <= 1'b0;
    end else begin
      go_q <= go;
      case (state)
        IDLE, DONE: begin
          if (go_rise) begin
            term_cnt <= '0;
            err_idx  <= '0;
            err_val  <= '0;
            err_seen <= 1'b0;
            tmo      <= 1'b0;
            exp_ph   <= 1'b1;
            fib_ack  <= 1'b0;
            gold_a   <= '0;
            gold_b   <= WIDTH'(1);
            rst_cnt  <= RC_W'(RST_CYC - 1);
          end
        end
        RST:   if (rst_cnt != '0) rst_cnt <= rst_cnt - RC_W'(1);
        START: tmr <= TMR_W'(TMO_CYC - 1);
        WAIT: begin
          // Accept wins over an expiring timer in the same cycle.
          if (accept)           acc_val <= value;
          else if (tmr != '0)   tmr     <= tmr - TMR_W'(1);
          else                  tmo     <= 1'b1;
        end
        CHECK: begin
          last_val <= acc_val;
          if ((acc_val != gold_a) && !err_seen) begin
            err_seen <= 1'b1;
            err_idx  <= term_cnt;
            err_val  <= acc_val;
          end
          gold_a   <= gold_b;
          gold_b   <= gold_a + gold_b;
          term_cnt <= term_inc[CNT_W] ? term_cnt : term_inc[CNT_W-1:0];
          fib_ack  <= ~fib_ack;
          exp_ph   <= ~exp_ph;
          tmr      <= TMR_W'(TMO_CYC - 1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_tp_seq_ctrl.sv
// Directed-random bench: a TP Fibonacci token source feeds the sequencer and
// results are compared with an arithmetic Fibonacci reference.
module tb_fib_tp_seq_ctrl;

  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int TMO = 64;
  localparam int RC  = 8;

  logic                 clk = 1'b0;
  logic                 rst, go;
  logic [CW-1:0]        n_terms;
  logic [W-1:0][1:0]    fib_in;
  logic                 fib_rst, fib_start, fib_ack, busy, done, pass, tmo;
  logic [CW-1:0]        term_cnt, err_idx;
  logic [W-1:0]         last_val, err_val;

  fib_tp_seq_ctrl #(.WIDTH(W), .RST_CYC(RC), .TMO_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .go(go), .n_terms(n_terms), .fib_in(fib_in),
    .fib_rst(fib_rst), .fib_start(fib_start), .fib_ack(fib_ack), .busy(busy),
    .done(done), .pass(pass), .term_cnt(term_cnt), .last_val(last_val),
    .err_idx(err_idx), .err_val(err_val), .tmo(tmo)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   ack_cnt = 0;
  logic ack_last = 1'b0;
  int   fib_ref [0:31];
  int   wc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every bench step goes through here so any ack edge is counted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (fib_ack !== ack_last) begin
      ack_cnt++;
      ack_last = fib_ack;
    end
  endtask

  task automatic put_token(input logic [W-1:0] v, input logic ph, input bit skew);
    logic [W-1:0][1:0] tgt, old;
    int d [W];
    int g;
    for (int i = 0; i < W; i++) tgt[i] = {v[i] ^ ph, v[i]};
    old = fib_in;
    if (!skew) begin
      fib_in = tgt;
      return;
    end
    g = int'($urandom_range(W - 1, 0));
    for (int i = 0; i < W; i++) d[i] = int'($urandom_range(3, 0));
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < W; i++) begin
        if (i == g) begin
          // One-cycle flip of the wrong rail: right phase, wrong value.
          if (c == 0 && ((old[i] ^ tgt[i]) == 2'b01 || (old[i] ^ tgt[i]) == 2'b10))
            fib_in[i] = old[i] ^ (2'b11 ^ (old[i] ^ tgt[i]));
          else if (c == 1) fib_in[i] = old[i];
          else if (c == 4) fib_in[i] = tgt[i];
        end else if (d[i] == c) begin
          fib_in[i] = tgt[i];
        end
      end
      tick();
    end
  endtask

  task automatic run(input int n, input int bad_k, input logic [W-1:0] bad_v,
                     input int stop_k, input bit skew, input bit wait_done,
                     output int wait_cyc);
    int t;
    int base;
    int tokens;
    logic [W-1:0] v;
    fib_in  = '0;
    n_terms = CW'(n);
    go      = 1'b1;
    tick();
    go      = 1'b0;
    ack_cnt = 0;
    tokens  = 0;
    t = 0;
    while (fib_start !== 1'b1 && t < 100) begin tick(); t++; end
    chk("start_seen", fib_start, 1);
    for (int k = 0; k < n && k != stop_k; k++) begin
      v = (k == bad_k) ? bad_v : W'(fib_ref[k]);
      repeat ($urandom_range(3, 0)) tick();
      base = ack_cnt;
      put_token(v, logic'(k % 2 == 0), skew);
      tokens++;
      t = 0;
      while (ack_cnt == base && t < 200) begin tick(); t++; end
      chk("ack_per_token", ack_cnt, base + 1);
      chk("last_val", last_val, v);
    end
    chk("ack_total", ack_cnt, tokens);
    wait_cyc = 0;
    if (wait_done)
      while (done !== 1'b1 && wait_cyc < TMO + 100) begin tick(); wait_cyc++; end
  endtask

  initial begin
    fib_ref[0] = 0;
    fib_ref[1] = 1;
    for (int k = 2; k < 32; k++) fib_ref[k] = (fib_ref[k-1] + fib_ref[k-2]) % (1 << W);

    rst = 1'b1; go = 1'b0; n_terms = '0; fib_in = '0;
    repeat (3) tick();
    chk("rst_fib_rst", fib_rst, 1);
    chk("rst_fib_start", fib_start, 0);
    chk("rst_fib_ack", fib_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_term_cnt", term_cnt, 0);
    chk("rst_last_val", last_val, 0);
    chk("rst_err_idx", err_idx, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean 10-term run
    run(10, -1, '0, -1, 1'b0, 1'b1, wc);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_term_cnt", term_cnt, 10);
    chk("t1_acks", ack_cnt, 10);
    chk("t1_last_val", last_val, 34);
    chk("t1_busy", busy, 0);
    chk("t1_fib_rst", fib_rst, 1);

    // Term 5 corrupted to 6
    run(10, 5, W'(6), -1, 1'b0, 1'b1, wc);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    chk("t2_err_idx", err_idx, 5);
    chk("t2_err_val", err_val, 6);
    chk("t2_term_cnt", term_cnt, 10);
    chk("t2_tmo", tmo, 0);

    // Source stalls after three tokens
    run(10, -1, '0, 3, 1'b0, 1'b1, wc);
    chk("t3_tmo", tmo, 1);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_term_cnt", term_cnt, 3);
    chk("t3_wait_cycles", wc, TMO);

    // Skewed and glitching rails
    run(10, -1, '0, -1, 1'b1, 1'b1, wc);
    chk("t4_pass", pass, 1);
    chk("t4_acks", ack_cnt, 10);
    chk("t4_term_cnt", term_cnt, 10);

    // Golden wraps at 2^W
    run(20, -1, '0, -1, 1'b0, 1'b1, wc);
    chk("t5_pass", pass, 1);
    chk("t5_term_cnt", term_cnt, 20);
    chk("t5_last_val", last_val, fib_ref[19]);

    // Async reset while waiting for term 4
    run(10, -1, '0, 4, 1'b0, 1'b0, wc);
    tick();
    tick();
    chk("t6_in_run", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_fib_rst", fib_rst, 1);
    chk("t6_fib_ack", fib_ack, 0);
    chk("t6_busy", busy, 0);
    chk("t6_start", fib_start, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_term_cnt_clr", term_cnt, 0);
    run(10, -1, '0, -1, 1'b1, 1'b1, wc);
    chk("t6_rerun_pass", pass, 1);
    chk("t6_rerun_cnt", term_cnt, 10);

    // Zero terms
    fib_in  = '0;
    n_terms = '0;
    go      = 1'b1;
    tick();
    go      = 1'b0;
    ack_cnt = 0;
    chk("t7_done", done, 1);
    chk("t7_pass", pass, 1);
    chk("t7_busy", busy, 0);
    chk("t7_fib_ack", fib_ack, 0);
    repeat (3) tick();
    chk("t7_no_ack", ack_cnt, 0);
    chk("t7_term_cnt", term_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
